// File: rtl/int_muldiv_unit.sv
// int_muldiv_unit: multi-cycle RV32M multiply/divide execute unit.
// Optional MULDIV_FAST_MUL_EN: single-cycle multiply path.
module int_muldiv_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [2:0]            op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic [TAG_WIDTH-1:0]  tag_i,
    input  logic                  flush_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic [TAG_WIDTH-1:0]  tag_o,
    output logic                  busy_o
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W + 1);
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        FIX,
        DONE
`ifdef MULDIV_FAST_MUL_EN
        , FMUL
`endif
    } state_t;

    state_t state, state_n;

    logic [2:0]    op_q;
    logic          neg_q;
    logic [W-1:0]  hi_q, lo_q, opnd_q;
    logic [CW-1:0] cnt_q;

    logic         accept;
    logic         a_sgn, b_sgn, a_neg, b_neg;
    logic         div_zero, div_ovf;
    logic [W-1:0] a_mag, b_mag, special;

    assign ready_o = (state == IDLE);
    assign valid_o = (state == DONE);
    assign busy_o  = (state != IDLE);
    assign accept  = valid_i && ready_o && !flush_i;

    always_comb begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        case (op_i)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                a_sgn = 1'b1;
                b_sgn = 1'b1;
            end
            3'b010:  a_sgn = 1'b1;
            default: ;
        endcase
    end

    assign a_neg    = a_sgn & a_i[W-1];
    assign b_neg    = b_sgn & b_i[W-1];
    assign a_mag    = a_neg ? -a_i : a_i;
    assign b_mag    = b_neg ? -b_i : b_i;
    assign div_zero = op_i[2] && (b_i == '0);
    assign div_ovf  = op_i[2] && !op_i[0] && (a_i == MIN_NEG) && (b_i == '1);
    assign special  = div_zero ? (op_i[1] ? a_i : '1)
                               : (op_i[1] ? '0 : a_i);

    // One iteration: shift-add for multiply, restoring step for divide.
    logic [W:0]   sum, shifted;
    logic [W+1:0] diff;
    logic [W-1:0] hi_n, lo_n;

    always_comb begin
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        shifted = {hi_q, lo_q[W-1]};
        diff    = {1'b0, shifted} - {2'b00, opnd_q};
        if (op_q[2]) begin
            if (diff[W+1]) begin
                hi_n = shifted[W-1:0];
                lo_n = {lo_q[W-2:0], 1'b0};
            end else begin
                hi_n = diff[W-1:0];
                lo_n = {lo_q[W-2:0], 1'b1};
            end
        end else begin
            hi_n = sum[W:1];
            lo_n = {sum[0], lo_q[W-1:1]};
        end
    end

    // The last iteration is folded into FIX together with sign correction.
    logic [2*W-1:0] prod, prod_c;
    logic [W-1:0]   quo_rem, fix_res;

    always_comb begin
`ifdef MULDIV_FAST_MUL_EN
        prod = (state == FMUL) ? (2*W)'(opnd_q) * (2*W)'(lo_q)
                               : {hi_n, lo_n};
`else
        prod = {hi_n, lo_n};
`endif
        prod_c  = neg_q ? -prod : prod;
        quo_rem = op_q[1] ? hi_n : lo_n;
        if (op_q[2]) begin
            fix_res = neg_q ? -quo_rem : quo_rem;
        end else if (op_q[1:0] == 2'b00) begin
            fix_res = prod_c[W-1:0];
        end else begin
            fix_res = prod_c[2*W-1:W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (valid_i) begin
                    if (div_zero || div_ovf) state_n = DONE;
`ifdef MULDIV_FAST_MUL_EN
                    else if (!op_i[2])       state_n = FMUL;
`endif
                    else                     state_n = CALC;
                end
            end
            CALC: if (cnt_q == CW'(2)) state_n = FIX;
            FIX:  state_n = DONE;
`ifdef MULDIV_FAST_MUL_EN
            FMUL: state_n = DONE;
`endif
            DONE: if (ready_i) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (flush_i) state_n = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_o <= '0;
            tag_o    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
        end else if (accept) begin
            tag_o <= tag_i;
            op_q  <= op_i;
            neg_q <= (op_i[2] && op_i[1]) ? a_neg : (a_neg ^ b_neg);
            cnt_q <= CW'(W);
            hi_q  <= '0;
            if (op_i[2]) begin
                lo_q   <= a_mag;
                opnd_q <= b_mag;
            end else begin
                lo_q   <= b_mag;
                opnd_q <= a_mag;
            end
            if (div_zero || div_ovf) result_o <= special;
        end else if (state == CALC) begin
            hi_q  <= hi_n;
            lo_q  <= lo_n;
            cnt_q <= cnt_q - CW'(1);
        end else if (state == FIX
`ifdef MULDIV_FAST_MUL_EN
                     || state == FMUL
`endif
                    ) begin
            result_o <= fix_res;
        end
    end

endmodule

// File: doc/int_muldiv_unit.md
# int_muldiv_unit

Multi-cycle RV32M execute unit implementing all eight M-extension operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) over a parametrised data width. It sits beside the single-cycle integer ALU in the integer path of the execute stage. A valid/ready handshake on both sides lets it stall issue and hold results under writeback backpressure. A tag travels with each operation so writeback can match the result to its destination register.

## Interface
- DATA_WIDTH, 32, operand/result width; any even value ≥ 8
- TAG_WIDTH, 5, width of the pass-through destination tag
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- valid_i  in  1  operation request
- ready_o  out  1  unit can accept; high only in IDLE
- op_i  in  3  funct3 (instr[14:12]): 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- a_i  in  DATA_WIDTH  rs1 operand
- b_i  in  DATA_WIDTH  rs2 operand
- tag_i  in  TAG_WIDTH  destination tag
- flush_i  in  1  kill the in-flight operation
- valid_o  out  1  result available
- ready_i  in  1  consumer accepts result
- result_o  out  DATA_WIDTH  result
- tag_o  out  TAG_WIDTH  tag captured with the operation
- busy_o  out  1  state != IDLE

## Operation
- States: IDLE, CALC, FIX, DONE.
- Accept: on a rising edge with valid_i && ready_o, register op, a, b and tag.
- Accept, divide by zero (b == 0, op 1xx): go directly to DONE.
  - DIV/DIVU result = all ones.
  - REM/REMU result = a.
- Accept, signed overflow (DIV/REM, a = 100…0, b = all ones): go directly to DONE.
  - DIV result = a.
  - REM result = 0.
- All other accepts go to CALC with counter = DATA_WIDTH.
- Divide, CALC:
  - Restoring divide, one quotient bit per cycle.
  - Operands are converted to magnitudes first for signed ops (DIV/REM).
  - Counter decrements each cycle; go to FIX when the counter reaches 1.
- Multiply, CALC: shift-add, one multiplier bit per cycle, into a 2·DATA_WIDTH accumulator.
  - MULHSU treats b as unsigned.
  - MULHU treats both operands as unsigned.
- FIX (one cycle):
  - Apply sign correction:
    - Quotient negated if the operand signs differ.
    - Remainder takes the sign of the dividend.
    - Product negated if the signs differ (signed operands only).
  - Select the result: low half for MUL, high half for MULH*.
  - Go to DONE.
- DONE: valid_o = 1. result_o and tag_o are stable. On valid_o && ready_i, go to IDLE.
- flush_i: synchronous, from any state. Next state is IDLE and valid_o drops next cycle. The killed operation never produces a result. flush_i outranks the DONE handshake and a same-cycle accept.
- rst: same effect as flush_i, at any point including mid-operation. After reset, all registered outputs are 0.

## Timing
- Reset values:
  - valid_o = 0, result_o = 0, tag_o = 0, busy_o = 0.
  - ready_o = 1 (IDLE).
- Latency is counted from the accept edge to the first cycle with valid_o = 1:
  - Normal mul/div: DATA_WIDTH+1 edges (DATA_WIDTH CALC + 1 FIX). For DATA_WIDTH = 32, valid_o is high in the cycle after the 33rd edge.
  - Divide-by-zero and overflow: 1 edge.
  - MULDIV_FAST_MUL_EN multiply: 2 edges.
- Throughput: one operation in flight. ready_o is low from the edge after accept until the edge that completes the DONE handshake, so there are no back-to-back accepts.
- Once valid_o = 1, result_o and tag_o must not change until the handshake or flush/reset.
- Input operands are sampled only at the accept edge; later changes on a_i, b_i, op_i and tag_i are ignored.

## Configuration
- MULDIV_FAST_MUL_EN defined:
  - Multiplies use a single-cycle 2·DATA_WIDTH product computed from the registered operands, written in a state replacing CALC/FIX.
  - Multiply latency is 2 edges.
  - Divides are unchanged.
- Not defined: multiplies use the shared iterative datapath, latency DATA_WIDTH+1, and no hardware multiplier is inferred.
- Results are identical in both builds.

## Test plan
- W=32, a = b = 0xFFFFFFFF: MUL → 0x00000001, MULH → 0x00000000, MULHU → 0xFFFFFFFE, MULHSU → 0xFFFFFFFF. Latency 33 (or 2 with fast mul).
- DIV a=−7 (0xFFFFFFF9), b=2 → 0xFFFFFFFD. REM → 0xFFFFFFFF. DIVU 7/2 → 3. REMU 7/2 → 1. valid_o first high exactly 33 cycles after accept.
- DIVU 5/0 → 0xFFFFFFFF and REMU 5/0 → 5, each with valid_o 1 cycle after accept. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, and REM → 0, also latency 1.
- Backpressure: ready_i held low 10 cycles in DONE → valid_o, result_o and tag_o stay constant, ready_o stays 0. Then ready_i=1 → IDLE next cycle and ready_o=1.
- Flush at the 10th CALC cycle → IDLE next cycle and valid_o never rises. A following DIV 100/7 (tag 5) returns 14 with tag_o = 5. Repeat the same sequence with rst instead of flush.
- Change a_i, b_i and op_i every cycle while busy → the result matches the operands latched at accept.
